pwm_duty_gen: RTL
=================

Name: pwm_duty_gen

Overview:
- Generates the PWM signal FREC consumed by the motor/LED selector stage.
- Duty cycle is set by two push-buttons (up/down), debounced in-block, and changes in fixed steps with saturation.
- Duty changes take effect only at a PWM period boundary, so FREC never glitches.
- Current duty and a limit flag are exported for display.

Parameters:
- PWM_BITS, 8, width of PWM counter and duty; period = 2^PWM_BITS ticks.
- PRESC, 196, clock cycles per PWM tick. Must be >= 1. At 50 MHz with PWM_BITS=8 this gives ≈1 kHz.
- DEB_CYCLES, 500000, consecutive stable cycles required to accept a button level change (10 ms at 50 MHz).
- STEP, 16, duty increment/decrement per accepted press.
- DUTY_INIT, 128, duty after reset. Must be <= 2^PWM_BITS-1.

Ports:
- CLK  input  1  system clock; all logic on rising edge.
- RST_N  input  1  asynchronous, active-low reset.
- BTN_UP  input  1  raw button, active-high, asynchronous to CLK.
- BTN_DOWN  input  1  raw button, active-high, asynchronous to CLK.
- FREC  output  1  PWM output, registered.
- DUTY  output  PWM_BITS  duty currently applied (duty_act).
- LIMIT  output  1  high while requested duty is 0 or 2^PWM_BITS-1.

Behaviour:
- Reset (RST_N low, asynchronous) sets:
  - prescaler = 0, pwm_cnt = 0, FREC = 0.
  - duty_req = duty_act = DUTY_INIT.
  - both debouncers IDLE with stable level 0 and counter 0.
  - LIMIT = DUTY_INIT is 0 or max.
  - Deassertion takes effect on the next CLK edge.
  - Reset mid-press or mid-period discards all progress; no pulse is emitted.
- Prescaler:
  - Counts 0..PRESC-1 and wraps.
  - tick = 1 for one cycle when the count equals PRESC-1.
  - PRESC=1 gives tick every cycle.
- PWM counter:
  - pwm_cnt increments on tick and wraps from 2^PWM_BITS-1 to 0.
  - Period boundary = tick && pwm_cnt == 2^PWM_BITS-1. On that cycle duty_act <= duty_req.
- Output:
  - FREC <= (pwm_cnt < duty_act), registered, so 1 cycle latency from the counter.
  - duty_act = 0: FREC constantly 0.
  - duty_act = max: FREC high for 2^PWM_BITS-1 of 2^PWM_BITS ticks.
- Synchronizer: each button passes through a 2-flop synchronizer before its debouncer.
- Debouncer FSM, per button. States are IDLE, CHECK_PRESS, PRESSED, CHECK_RELEASE.
  - IDLE: sync=1 -> CHECK_PRESS, counter cleared.
  - CHECK_PRESS: counter increments each cycle while sync=1.
    - sync=0 -> IDLE.
    - counter reaches DEB_CYCLES-1 -> PRESSED, emitting a 1-cycle press pulse on that transition.
  - PRESSED: sync=0 -> CHECK_RELEASE, counter cleared.
  - CHECK_RELEASE: sync=1 -> PRESSED.
    - DEB_CYCLES-1 consecutive cycles of 0 -> IDLE.
  - Holding a button produces exactly one pulse; there is no auto-repeat.
- Duty update, computed in PWM_BITS+1 bits on the cycle after a pulse:
  - up only: duty_req <= min(duty_req+STEP, 2^PWM_BITS-1).
  - down only: duty_req <= max(duty_req-STEP, 0), with no underflow wrap.
  - up and down pulses on the same cycle: no change.
  - A pulse arriving on a period-boundary cycle updates duty_req. duty_act takes the old duty_req, so the new value applies at the next boundary.
- LIMIT is combinational from duty_req.

Decomposition:
- Shared package `pwm_pkg`:
  - debouncer state encoding: IDLE=2'b00, CHECK_PRESS=2'b01, PRESSED=2'b10, CHECK_RELEASE=2'b11.
  - default constants PWM_BITS, STEP, DEB_CYCLES.
  - clog2 helper for counter widths.
- Sub-module `debounce_pulse`: synchronizer + FSM + counter + press pulse.
  - Parameter DEB_CYCLES.
  - Ports CLK, RST_N, BTN, PULSE.
  - Instantiated twice.

Test Plan:
Bench parameters: PWM_BITS=4, PRESC=2, DEB_CYCLES=4, STEP=4, DUTY_INIT=8.
1. Reset release, no buttons -> DUTY=8. FREC high 8 ticks (16 CLK) then low 8 ticks per 32-cycle period. LIMIT=0.
2. BTN_UP held 20 cycles -> exactly one pulse, duty_req=12. DUTY stays 8 until the next period boundary, then 12. FREC high 24 CLK per period.
3. Four separated BTN_UP presses from 8 -> duty_req 12, 15, 15, 15. LIMIT=1 from the first 15.
   Then 4 BTN_DOWN presses -> 11, 7, 3, 0. FREC constantly 0 once DUTY=0. LIMIT=1.
4. BTN_UP toggling every 2 cycles for 30 cycles (bounce), then released -> no pulse, duty unchanged.
5. BTN_UP and BTN_DOWN asserted simultaneously and held -> both pulses on the same cycle, duty_req unchanged.
6. RST_N pulled low mid-period with duty 12 and BTN_UP in CHECK_PRESS -> FREC=0, DUTY=8 immediately. Counters 0, no pulse after release.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared types and defaults for the PWM duty generator.
// Debouncer state encoding and a width helper.
package pwm_pkg;

  typedef enum logic [1:0] {
    IDLE          = 2'b00,
    CHECK_PRESS   = 2'b01,
    PRESSED       = 2'b10,
    CHECK_RELEASE = 2'b11
  } deb_state_t;

  localparam int PWM_BITS_D   = 8;
  localparam int STEP_D       = 16;
  localparam int DEB_CYCLES_D = 500000;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/debounce_pulse.sv
// Button synchronizer and debouncer.
// Emits a one-cycle registered pulse per accepted press.
module debounce_pulse
  import pwm_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_D
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic BTN,
  output logic PULSE
);

  localparam int CW =
    (clog2(DEB_CYCLES) < 1) ? 1 : clog2(DEB_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEB_CYCLES - 1);

  logic [1:0]  sync_q;
  logic        sync;
  deb_state_t  state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic        pulse_n;

  assign sync = sync_q[1];

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync_q <= '0;
      state  <= IDLE;
      cnt    <= '0;
      PULSE  <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], BTN};
      state  <= state_n;
      cnt    <= cnt_n;
      PULSE  <= pulse_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    pulse_n = 1'b0;
    unique case (state)
      IDLE: begin
        if (sync) begin
          state_n = CHECK_PRESS;
          cnt_n   = '0;
        end
      end
      CHECK_PRESS: begin
        if (!sync) begin
          state_n = IDLE;
        end else if (cnt == LAST) begin
          state_n = PRESSED;
          pulse_n = 1'b1;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      PRESSED: begin
        if (!sync) begin
          state_n = CHECK_RELEASE;
          cnt_n   = '0;
        end
      end
      CHECK_RELEASE: begin
        if (sync) begin
          state_n = PRESSED;
        end else if (cnt == LAST) begin
          state_n = IDLE;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
    endcase
  end

endmodule

// File: rtl/pwm_duty_gen.sv
// PWM generator with button-controlled duty cycle.
// Duty requests are applied only at period boundaries.
module pwm_duty_gen
  import pwm_pkg::*;
#(
  parameter int PWM_BITS   = PWM_BITS_D,
  parameter int PRESC      = 196,
  parameter int DEB_CYCLES = DEB_CYCLES_D,
  parameter int STEP       = STEP_D,
  parameter int DUTY_INIT  = 128
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                BTN_UP,
  input  logic                BTN_DOWN,
  output logic                FREC,
  output logic [PWM_BITS-1:0] DUTY,
  output logic                LIMIT
);

  localparam int PW =
    (clog2(PRESC) < 1) ? 1 : clog2(PRESC);
  localparam logic [PW-1:0] PLAST = PW'(PRESC - 1);
  localparam logic [PWM_BITS-1:0] DMAX = '1;
  localparam logic [PWM_BITS:0] WMAX = {1'b0, DMAX};
  localparam logic [PWM_BITS:0] WSTEP =
    (PWM_BITS + 1)'(STEP);
  localparam logic [PWM_BITS-1:0] DINIT =
    PWM_BITS'(DUTY_INIT);

  logic [PW-1:0]       presc;
  logic                tick;
  logic                boundary;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [PWM_BITS-1:0] duty_req;
  logic [PWM_BITS-1:0] duty_act;
  logic [PWM_BITS-1:0] req_n;
  logic [PWM_BITS:0]   sum;
  logic [PWM_BITS:0]   diff;
  logic                up;
  logic                down;

  debounce_pulse #(.DEB_CYCLES(DEB_CYCLES)) u_up (
    .CLK  (CLK),
    .RST_N(RST_N),
    .BTN  (BTN_UP),
    .PULSE(up)
  );

  debounce_pulse #(.DEB_CYCLES(DEB_CYCLES)) u_down (
    .CLK  (CLK),
    .RST_N(RST_N),
    .BTN  (BTN_DOWN),
    .PULSE(down)
  );

  assign tick     = (presc == PLAST);
  assign boundary = tick && (pwm_cnt == DMAX);
  assign sum      = {1'b0, duty_req} + WSTEP;
  assign diff     = {1'b0, duty_req} - WSTEP;

  // Extra bit catches overflow and underflow before saturating.
  always_comb begin
    req_n = duty_req;
    unique case (1'b1)
      up && !down:
        req_n = (sum > WMAX) ? DMAX : sum[PWM_BITS-1:0];
      down && !up:
        req_n = ({1'b0, duty_req} < WSTEP) ?
          '0 : diff[PWM_BITS-1:0];
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      presc    <= '0;
      pwm_cnt  <= '0;
      FREC     <= 1'b0;
      duty_req <= DINIT;
      duty_act <= DINIT;
    end else begin
      presc    <= tick ? '0 : presc + 1'b1;
      if (tick) pwm_cnt <= pwm_cnt + 1'b1;
      if (boundary) duty_act <= duty_req;
      duty_req <= req_n;
      FREC     <= (pwm_cnt < duty_act);
    end
  end

  assign DUTY  = duty_act;
  assign LIMIT = (duty_req == '0) || (duty_req == DMAX);

endmodule
